tile_rom_fetch_arbiter: RTL and testbench

//  Shares one SDRAM tile-ROM read port between the tile-layer fetch clients (layer A, layer B, ...).

---
 rtl/tile_rom_fetch_arbiter.sv | 146 ++++++++++++++
 tb/tb_tile_rom_fetch_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_rom_fetch_arbiter.sv
// Round-robin arbiter sharing one SDRAM tile-ROM read port among N layer clients.
// Latches 1-cycle client pulses, issues one read at a time, returns data with a 1-cycle strobe.
module tile_rom_fetch_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 20,
    parameter int TIMEOUT   = 255
) (
    input  logic                        CLK_32M,
    input  logic                        RESET_N,
    input  logic [N_CLIENTS-1:0]        cl_req,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    output logic [31:0]                 cl_data,
    output logic [N_CLIENTS-1:0]        cl_rdy,
    output logic                        rom_req,
    output logic [ADDR_W-1:0]           rom_addr,
    output logic [1:0]                  rom_sel,
    input  logic [31:0]                 rom_data,
    input  logic                        rom_rdy,
    output logic [N_CLIENTS-1:0]        overrun,
    output logic                        timeout_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [N_CLIENTS-1:0]  pend;
    logic [ADDR_W-1:0]     paddr [N_CLIENTS];
    logic [1:0]            rr_ptr, cur, rr_next;
    logic [7:0]            tmo;

    logic                  found_hi, found_lo;
    logic [1:0]            idx_hi, idx_lo;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic [ADDR_W-1:0]     grant_addr;
    logic [N_CLIENTS-1:0]  grant_mask;
    logic [N_CLIENTS-1:0]  cur_onehot;
    logic                  read_done, read_abort;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        // Descending scan: the last hit is the lowest index, both overall and at/above rr_ptr.
        for (int j = N_CLIENTS - 1; j >= 0; j--) begin
            if (pend[j]) begin
                found_lo = 1'b1;
                idx_lo   = 2'(j);
                if (2'(j) >= rr_ptr) begin
                    found_hi = 1'b1;
                    idx_hi   = 2'(j);
                end
            end
        end
        grant_valid = (state_q == S_IDLE) && found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;

        grant_addr = '0;
        grant_mask = '0;
        cur_onehot = '0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            if (grant_idx == 2'(j)) begin
                grant_addr    = paddr[j];
                grant_mask[j] = grant_valid;
            end
            cur_onehot[j] = (cur == 2'(j));
        end

        read_done  = (state_q == S_WAIT) && rom_rdy;
        read_abort = (state_q == S_WAIT) && !rom_rdy && (tmo == 8'(TIMEOUT));
        rr_next    = (cur == 2'(N_CLIENTS - 1)) ? 2'd0 : cur + 2'd1;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_valid) state_d = S_WAIT;
            S_WAIT:  if (read_done || read_abort) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    assign rom_req = (state_q == S_WAIT);

    // NOTE: the address store is plain storage qualified by pend, so it carries no reset.
    always_ff @(posedge CLK_32M) begin
        for (int j = 0; j < N_CLIENTS; j++) begin
            if (cl_req[j]) paddr[j] <= cl_addr[j*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            pend        <= '0;
            overrun     <= '0;
            rr_ptr      <= '0;
            cur         <= '0;
            tmo         <= '0;
            rom_addr    <= '0;
            rom_sel     <= '0;
            cl_rdy      <= '0;
            cl_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            cl_rdy <= '0;

            // A request landing in its own grant cycle re-arms pend without flagging overrun.
            for (int j = 0; j < N_CLIENTS; j++) begin
                if (cl_req[j]) begin
                    pend[j] <= 1'b1;
                    if (pend[j] && !grant_mask[j]) overrun[j] <= 1'b1;
                end else if (grant_mask[j]) begin
                    pend[j] <= 1'b0;
                end
            end

            if (grant_valid) begin
                rom_addr <= grant_addr;
                rom_sel  <= grant_idx;
                cur      <= grant_idx;
                tmo      <= '0;
            end

            if (state_q == S_WAIT) begin
                tmo <= tmo + 8'd1;
                if (read_done) begin
                    cl_data <= rom_data;
                    cl_rdy  <= cur_onehot;
                    rr_ptr  <= rr_next;
                end else if (read_abort) begin
                    cl_data     <= '0;
                    cl_rdy      <= cur_onehot;
                    rr_ptr      <= rr_next;
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tile_rom_fetch_arbiter.sv
// Directed bench for tile_rom_fetch_arbiter: two clients, hand-computed expectations per scenario.
module tb_tile_rom_fetch_arbiter;

    localparam int N_CLIENTS = 2;
    localparam int ADDR_W    = 20;
    localparam int TIMEOUT   = 255;

    logic                        clk;
    logic                        rst_n;
    logic [N_CLIENTS-1:0]        cl_req;
    logic [N_CLIENTS*ADDR_W-1:0] cl_addr;
    logic [31:0]                 cl_data;
    logic [N_CLIENTS-1:0]        cl_rdy;
    logic                        rom_req;
    logic [ADDR_W-1:0]           rom_addr;
    logic [1:0]                  rom_sel;
    logic [31:0]                 rom_data;
    logic                        rom_rdy;
    logic [N_CLIENTS-1:0]        overrun;
    logic                        timeout_err;

    int errors = 0;
    int checks = 0;

    tile_rom_fetch_arbiter #(
        .N_CLIENTS(N_CLIENTS),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK_32M    (clk),
        .RESET_N    (rst_n),
        .cl_req     (cl_req),
        .cl_addr    (cl_addr),
        .cl_data    (cl_data),
        .cl_rdy     (cl_rdy),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_sel    (rom_sel),
        .rom_data   (rom_data),
        .rom_rdy    (rom_rdy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cl_req   = '0;
        cl_addr  = '0;
        rom_rdy  = 1'b0;
        rom_data = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_req(input logic [1:0] mask, input logic [19:0] a0, input logic [19:0] a1);
        cl_req  = mask;
        cl_addr = {a1, a0};
        tick();
        cl_req  = '0;
    endtask

    task automatic respond(input logic [31:0] d);
        rom_rdy  = 1'b1;
        rom_data = d;
        tick();
        rom_rdy  = 1'b0;
        rom_data = 32'h0BAD_0BAD;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({rom_req, rom_addr, rom_sel, cl_rdy, cl_data, overrun, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h sel=%0d rdy=%b data=%h ovr=%b tmo=%b, expected all 0",
                     rom_req, rom_addr, rom_sel, cl_rdy, cl_data, overrun, timeout_err);
        end
    endtask

    task automatic test_single_read();
        pulse_req(2'b01, 20'h12345, 20'h0);
        checks++;
        if (rom_req !== 1'b0) begin
            errors++; $display("FAIL single_req_early: rom_req=%b expected 0", rom_req);
        end
        tick();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 20'h12345 || rom_sel !== 2'd0) begin
            errors++;
            $display("FAIL single_issue: req=%b addr=%h sel=%0d expected 1 12345 0", rom_req, rom_addr, rom_sel);
        end
        repeat (4) tick();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 20'h12345 || cl_rdy !== 2'b00) begin
            errors++;
            $display("FAIL single_hold: req=%b addr=%h rdy=%b expected 1 12345 00", rom_req, rom_addr, cl_rdy);
        end
        respond(32'hDEAD_BEEF);
        checks++;
        if (cl_rdy !== 2'b01 || cl_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_return: rdy=%b data=%h expected 01 deadbeef", cl_rdy, cl_data);
        end
        tick();
        checks++;
        if (cl_rdy !== 2'b00 || rom_req !== 1'b0 || cl_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_after: rdy=%b req=%b data=%h expected 00 0 deadbeef", cl_rdy, rom_req, cl_data);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        pulse_req(2'b11, 20'h00010, 20'h00020);
        tick();
        checks++;
        if (rom_sel !== 2'd0 || rom_addr !== 20'h00010) begin
            errors++; $display("FAIL rr_first: sel=%0d addr=%h expected 0 00010", rom_sel, rom_addr);
        end
        respond(32'h0000_00A0);
        checks++;
        if (cl_rdy !== 2'b01 || cl_data !== 32'h0000_00A0) begin
            errors++; $display("FAIL rr_first_data: rdy=%b data=%h expected 01 000000a0", cl_rdy, cl_data);
        end
        tick();
        checks++;
        if (rom_req !== 1'b1 || rom_sel !== 2'd1 || rom_addr !== 20'h00020 || cl_rdy !== 2'b00) begin
            errors++;
            $display("FAIL rr_second: req=%b sel=%0d addr=%h rdy=%b expected 1 1 00020 00",
                     rom_req, rom_sel, rom_addr, cl_rdy);
        end
        respond(32'h0000_00B0);
        checks++;
        if (cl_rdy !== 2'b10 || cl_data !== 32'h0000_00B0) begin
            errors++; $display("FAIL rr_second_data: rdy=%b data=%h expected 10 000000b0", cl_rdy, cl_data);
        end
        // Serve client 0 alone so the pointer moves to 1; then a joint request must favour client 1.
        tick();
        pulse_req(2'b01, 20'h00030, 20'h0);
        tick();
        respond(32'h0000_00C0);
        tick();
        pulse_req(2'b11, 20'h00040, 20'h00050);
        tick();
        checks++;
        if (rom_sel !== 2'd1 || rom_addr !== 20'h00050) begin
            errors++; $display("FAIL rr_repeat_first: sel=%0d addr=%h expected 1 00050", rom_sel, rom_addr);
        end
        respond(32'h0000_00D0);
        checks++;
        if (cl_rdy !== 2'b10) begin
            errors++; $display("FAIL rr_repeat_rdy: rdy=%b expected 10", cl_rdy);
        end
        tick();
        checks++;
        if (rom_sel !== 2'd0 || rom_addr !== 20'h00040 || rom_req !== 1'b1) begin
            errors++;
            $display("FAIL rr_repeat_second: req=%b sel=%0d addr=%h expected 1 0 00040", rom_req, rom_sel, rom_addr);
        end
        respond(32'h0000_00E0);
        tick();
    endtask

    task automatic test_overrun();
        apply_reset();
        pulse_req(2'b01, 20'h00400, 20'h0);
        tick();
        pulse_req(2'b10, 20'h0, 20'h00100);
        checks++;
        if (overrun !== 2'b00) begin
            errors++; $display("FAIL overrun_first: overrun=%b expected 00", overrun);
        end
        pulse_req(2'b10, 20'h0, 20'h00200);
        checks++;
        if (overrun !== 2'b10) begin
            errors++; $display("FAIL overrun_set: overrun=%b expected 10", overrun);
        end
        respond(32'h0000_0011);
        checks++;
        if (cl_rdy !== 2'b01 || cl_data !== 32'h0000_0011) begin
            errors++; $display("FAIL overrun_c0_data: rdy=%b data=%h expected 01 00000011", cl_rdy, cl_data);
        end
        tick();
        checks++;
        if (rom_sel !== 2'd1 || rom_addr !== 20'h00200) begin
            errors++; $display("FAIL overrun_latest: sel=%0d addr=%h expected 1 00200", rom_sel, rom_addr);
        end
        respond(32'h0000_0022);
        checks++;
        if (cl_rdy !== 2'b10 || cl_data !== 32'h0000_0022) begin
            errors++; $display("FAIL overrun_c1_data: rdy=%b data=%h expected 10 00000022", cl_rdy, cl_data);
        end
        tick();
        checks++;
        if (rom_req !== 1'b0 || overrun !== 2'b10) begin
            errors++; $display("FAIL overrun_single_read: req=%b overrun=%b expected 0 10", rom_req, overrun);
        end
    endtask

    task automatic test_timeout();
        bit held;
        apply_reset();
        pulse_req(2'b01, 20'h00555, 20'h0);
        tick();
        respond(32'hCAFE_F00D);
        tick();
        pulse_req(2'b01, 20'h00666, 20'h0);
        tick();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 20'h00666) begin
            errors++; $display("FAIL tmo_issue: req=%b addr=%h expected 1 00666", rom_req, rom_addr);
        end
        held = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            if (rom_req !== 1'b1 || cl_rdy !== 2'b00 || timeout_err !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL tmo_early: read ended before %0d wait cycles, got 0 expected 1", TIMEOUT);
        end
        tick();
        checks++;
        if (rom_req !== 1'b0 || cl_rdy !== 2'b01 || cl_data !== 32'h0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_abort: req=%b rdy=%b data=%h err=%b expected 0 01 00000000 1",
                     rom_req, cl_rdy, cl_data, timeout_err);
        end
        tick();
        respond(32'h1234_5678);
        checks++;
        if (cl_rdy !== 2'b00 || cl_data !== 32'h0 || rom_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_rdy: rdy=%b data=%h req=%b expected 00 00000000 0", cl_rdy, cl_data, rom_req);
        end
        tick();
        checks++;
        if (cl_rdy !== 2'b00) begin
            errors++; $display("FAIL tmo_late_rdy2: rdy=%b expected 00", cl_rdy);
        end
    endtask

    task automatic test_reset_mid_wait();
        pulse_req(2'b01, 20'h00777, 20'h0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_req, rom_addr, rom_sel, cl_rdy, cl_data, overrun, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rst_async: req=%b addr=%h sel=%0d rdy=%b data=%h ovr=%b tmo=%b, expected all 0",
                     rom_req, rom_addr, rom_sel, cl_rdy, cl_data, overrun, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        respond(32'h5555_AAAA);
        checks++;
        if (cl_rdy !== 2'b00 || cl_data !== 32'h0 || rom_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_rdy: rdy=%b data=%h req=%b expected 00 00000000 0", cl_rdy, cl_data, rom_req);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        pulse_req(2'b01, 20'h0000A, 20'h0);
        pulse_req(2'b01, 20'h0000B, 20'h0);
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 20'h0000A || overrun !== 2'b00) begin
            errors++;
            $display("FAIL b2b_grant: req=%b addr=%h ovr=%b expected 1 0000a 00", rom_req, rom_addr, overrun);
        end
        respond(32'h0000_0AAA);
        checks++;
        if (cl_rdy !== 2'b01 || cl_data !== 32'h0000_0AAA) begin
            errors++; $display("FAIL b2b_first_data: rdy=%b data=%h expected 01 00000aaa", cl_rdy, cl_data);
        end
        tick();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 20'h0000B || rom_sel !== 2'd0 || overrun !== 2'b00) begin
            errors++;
            $display("FAIL b2b_second: req=%b addr=%h sel=%0d ovr=%b expected 1 0000b 0 00",
                     rom_req, rom_addr, rom_sel, overrun);
        end
        respond(32'h0000_0BBB);
        checks++;
        if (cl_rdy !== 2'b01 || cl_data !== 32'h0000_0BBB) begin
            errors++; $display("FAIL b2b_second_data: rdy=%b data=%h expected 01 00000bbb", cl_rdy, cl_data);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cl_req   = '0;
        cl_addr  = '0;
        rom_rdy  = 1'b0;
        rom_data = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
